// File: rtl/dm_sysbus_access_pkg.sv
// Shared constants for the debug-module system bus access engine:
// sberror codes and sbaccess size encodings.
package dm_sysbus_access_pkg;

    localparam logic [2:0] SbErrNone = 3'd0;
    localparam logic [2:0] SbErrSize = 3'd4;

    localparam logic [2:0] SbAccess8   = 3'd0;
    localparam logic [2:0] SbAccess16  = 3'd1;
    localparam logic [2:0] SbAccess32  = 3'd2;
    localparam logic [2:0] SbAccess64  = 3'd3;
    localparam logic [2:0] SbAccess128 = 3'd4;

endpackage

// File: rtl/dm_sba_be_gen.sv
// Byte-enable generator: turns an sbaccess size and address offset into a
// lane mask, the size-aligned offset and a flag for sizes wider than the bus.
module dm_sba_be_gen #(
    parameter int BusWidth = 32,
    localparam int NumBytes = BusWidth / 8,
    localparam int OffW = $clog2(NumBytes)
) (
    input  logic [2:0]          sbaccess,
    input  logic [OffW-1:0]     offset,
    output logic [NumBytes-1:0] be,
    output logic [OffW-1:0]     aligned_offset,
    output logic                size_ok
);

    localparam logic [2:0] MaxAccess = 3'(OffW);

    logic [OffW-1:0] align_mask;

    assign size_ok = sbaccess <= MaxAccess;

    // Sizes at or above the bus width wrap the shift to zero, clearing the offset.
    assign align_mask     = ~((OffW'(1) << sbaccess) - OffW'(1));
    assign aligned_offset = offset & align_mask;

    always_comb begin
        be = '0;
        for (int i = 0; i < NumBytes; i++) begin
            be[i] = size_ok && (i >= int'(aligned_offset))
                    && (i < int'(aligned_offset) + (1 << sbaccess));
        end
    end

endmodule

// File: rtl/dm_sysbus_access.sv
// System bus access engine: turns sbaddress/sbdata CSR events into single-beat
// bus reads and writes. Auto-increment is built only with DM_SBA_AUTOINCREMENT_EN.
module dm_sysbus_access
    import dm_sysbus_access_pkg::*;
#(
    parameter int BusWidth = 32,
    localparam int NumBytes = BusWidth / 8,
    localparam int OffW = $clog2(NumBytes)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                dmactive_i,
    output logic                master_req_o,
    output logic [BusWidth-1:0] master_add_o,
    output logic                master_we_o,
    output logic [BusWidth-1:0] master_wdata_o,
    output logic [NumBytes-1:0] master_be_o,
    input  logic                master_gnt_i,
    input  logic                master_r_valid_i,
    input  logic [BusWidth-1:0] master_r_rdata_i,
    input  logic [BusWidth-1:0] sbaddress_i,
    output logic [BusWidth-1:0] sbaddress_o,
    input  logic                sbaddress_write_valid_i,
    input  logic                sbreadonaddr_i,
    input  logic                sbautoincrement_i,
    input  logic                sbreadondata_i,
    input  logic [2:0]          sbaccess_i,
    input  logic [BusWidth-1:0] sbdata_i,
    input  logic                sbdata_read_valid_i,
    input  logic                sbdata_write_valid_i,
    output logic [BusWidth-1:0] sbdata_o,
    output logic                sbdata_valid_o,
    output logic                sbbusy_o,
    output logic                sberror_valid_o,
    output logic [2:0]          sberror_o
);

    typedef enum logic [2:0] {
        Idle,
        Read,
        Write,
        WaitRead,
        WaitWrite
    } state_e;

    state_e state_q, state_d;

    logic [OffW-1:0]     offset;
    logic [OffW-1:0]     aligned_offset;
    logic [NumBytes-1:0] be;
    logic                size_ok;
    logic                complete;
    logic                req;
    logic                we;

    assign offset = sbaddress_i[OffW-1:0];

    dm_sba_be_gen #(.BusWidth(BusWidth)) u_be_gen (
        .sbaccess       (sbaccess_i),
        .offset         (offset),
        .be             (be),
        .aligned_offset (aligned_offset),
        .size_ok        (size_ok)
    );

    always_comb begin
        state_d         = state_q;
        req             = 1'b0;
        we              = 1'b0;
        complete        = 1'b0;
        sbdata_valid_o  = 1'b0;
        sberror_valid_o = 1'b0;
        sberror_o       = SbErrNone;

        case (state_q)
            Idle: begin
                if (sbaddress_write_valid_i && sbreadonaddr_i) begin
                    state_d = Read;
                end else if (sbdata_write_valid_i) begin
                    state_d = Write;
                end else if (sbdata_read_valid_i && sbreadondata_i) begin
                    state_d = Read;
                end
            end
            Read: begin
                req = 1'b1;
                if (master_gnt_i) state_d = WaitRead;
            end
            Write: begin
                req = 1'b1;
                we  = 1'b1;
                if (master_gnt_i) state_d = WaitWrite;
            end
            WaitRead: begin
                if (master_r_valid_i) begin
                    sbdata_valid_o = 1'b1;
                    complete       = 1'b1;
                    state_d        = Idle;
                end
            end
            WaitWrite: begin
                if (master_r_valid_i) begin
                    complete = 1'b1;
                    state_d  = Idle;
                end
            end
            default: state_d = Idle;
        endcase

        // An unsupported size aborts before anything reaches the bus.
        if (state_q != Idle && !size_ok) begin
            req             = 1'b0;
            we              = 1'b0;
            complete        = 1'b0;
            sbdata_valid_o  = 1'b0;
            sberror_valid_o = 1'b1;
            sberror_o       = SbErrSize;
            state_d         = Idle;
        end

        if (!dmactive_i) begin
            complete        = 1'b0;
            sbdata_valid_o  = 1'b0;
            sberror_valid_o = 1'b0;
            sberror_o       = SbErrNone;
            state_d         = Idle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= Idle;
        else         state_q <= state_d;
    end

    assign master_req_o   = req;
    assign master_we_o    = we;
    assign master_add_o   = sbaddress_i;
    assign master_be_o    = req ? be : '0;
    assign master_wdata_o = (req && we) ? (sbdata_i << {offset, 3'b000}) : '0;
    assign sbdata_o       = (state_q == WaitRead)
                            ? (master_r_rdata_i >> {aligned_offset, 3'b000}) : '0;
    assign sbbusy_o       = (state_q != Idle);

`ifdef DM_SBA_AUTOINCREMENT_EN
    assign sbaddress_o = (complete && sbautoincrement_i)
                         ? sbaddress_i + (BusWidth'(1) << sbaccess_i) : sbaddress_i;
`else
    logic unused_autoinc;
    assign unused_autoinc = ^{sbautoincrement_i, complete};
    assign sbaddress_o    = sbaddress_i;
`endif

endmodule

// File: tb/tb_dm_sysbus_access.sv
// Self-checking bench for dm_sysbus_access: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_dm_sysbus_access;

    localparam int BusWidth = 32;
`ifdef DM_SBA_AUTOINCREMENT_EN
    localparam bit AutoIncEn = 1'b1;
`else
    localparam bit AutoIncEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmactive;
    logic        req, we, gnt, rvalid;
    logic [31:0] add, wdata, rdata;
    logic [3:0]  be;
    logic [31:0] sbaddress, sbaddress_next, sbdata, sbdata_out;
    logic        addr_wv, roa, autoinc, rod, data_rv, data_wv;
    logic [2:0]  access;
    logic        dvalid, busy, errv;
    logic [2:0]  err;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    dm_sysbus_access #(.BusWidth(BusWidth)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .dmactive_i              (dmactive),
        .master_req_o            (req),
        .master_add_o            (add),
        .master_we_o             (we),
        .master_wdata_o          (wdata),
        .master_be_o             (be),
        .master_gnt_i            (gnt),
        .master_r_valid_i        (rvalid),
        .master_r_rdata_i        (rdata),
        .sbaddress_i             (sbaddress),
        .sbaddress_o             (sbaddress_next),
        .sbaddress_write_valid_i (addr_wv),
        .sbreadonaddr_i          (roa),
        .sbautoincrement_i       (autoinc),
        .sbreadondata_i          (rod),
        .sbaccess_i              (access),
        .sbdata_i                (sbdata),
        .sbdata_read_valid_i     (data_rv),
        .sbdata_write_valid_i    (data_wv),
        .sbdata_o                (sbdata_out),
        .sbdata_valid_o          (dvalid),
        .sbbusy_o                (busy),
        .sberror_valid_o         (errv),
        .sberror_o               (err)
    );

    typedef struct packed {
        logic        dmactive;
        logic [31:0] addr;
        logic        addr_wv, roa, autoinc, rod;
        logic [2:0]  access;
        logic [31:0] data;
        logic        data_rv, data_wv, gnt, rvalid;
        logic [31:0] rdata;
    } stim_t;

    typedef struct packed {
        logic        req, we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        busy, dvalid;
        logic [31:0] sbdata;
        logic        errv;
        logic [2:0]  err;
        logic [31:0] add;
        logic [31:0] addr_o;
    } expect_t;

    typedef struct packed {
        stim_t   s;
        expect_t e;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input stim_t s);
        dmactive  = s.dmactive;
        sbaddress = s.addr;
        addr_wv   = s.addr_wv;
        roa       = s.roa;
        autoinc   = s.autoinc;
        rod       = s.rod;
        access    = s.access;
        sbdata    = s.data;
        data_rv   = s.data_rv;
        data_wv   = s.data_wv;
        gnt       = s.gnt;
        rvalid    = s.rvalid;
        rdata     = s.rdata;
    endtask

    task automatic check_output(input string tag, input expect_t e);
        check({tag, " req"},     {31'b0, req},    {31'b0, e.req});
        check({tag, " be"},      {28'b0, be},     {28'b0, e.be});
        check({tag, " busy"},    {31'b0, busy},   {31'b0, e.busy});
        check({tag, " dvalid"},  {31'b0, dvalid}, {31'b0, e.dvalid});
        check({tag, " errv"},    {31'b0, errv},   {31'b0, e.errv});
        check({tag, " err"},     {29'b0, err},    {29'b0, e.err});
        check({tag, " add"},     add,             e.add);
        check({tag, " addr_o"},  sbaddress_next,  e.addr_o);
        if (e.req) begin
            check({tag, " we"}, {31'b0, we}, {31'b0, e.we});
            if (e.we) check({tag, " wdata"}, wdata, e.wdata);
        end
        if (e.dvalid) check({tag, " sbdata"}, sbdata_out, e.sbdata);
    endtask

    // One bus cycle: drive after the falling edge, sample before the rising edge.
    task automatic run_cycle(input string tag, input stim_t s, input expect_t e);
        @(negedge clk);
        apply_stimulus(s);
        #1;
        check_output(tag, e);
    endtask

    function automatic stim_t base_stim(input logic [31:0] addr, input logic [2:0] acc);
        stim_t s;
        s          = '0;
        s.dmactive = 1'b1;
        s.addr     = addr;
        s.access   = acc;
        return s;
    endfunction

    function automatic expect_t base_exp(input logic [31:0] addr);
        expect_t e;
        e        = '0;
        e.add    = addr;
        e.addr_o = addr;
        return e;
    endfunction

    task automatic push(input stim_t s, input expect_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] lane_mask(input logic [1:0] off, input int acc);
        int nbytes  = 1 << acc;
        int aligned = (int'(off) / nbytes) * nbytes;
        return 4'(((1 << nbytes) - 1) << aligned);
    endfunction

    function automatic int aligned_off(input logic [1:0] off, input int acc);
        int nbytes = 1 << acc;
        return (acc > 2) ? 0 : (int'(off) / nbytes) * nbytes;
    endfunction

    task automatic build_table();
        stim_t s;
        expect_t e;
        // Read on sbaddress write, immediate grant, response next cycle.
        s = base_stim(32'h1000, 3'd2); s.addr_wv = 1; s.roa = 1;
        e = base_exp(32'h1000); push(s, e);
        s = base_stim(32'h1000, 3'd2); s.gnt = 1;
        e = base_exp(32'h1000); e.req = 1; e.be = 4'hF; e.busy = 1; push(s, e);
        s = base_stim(32'h1000, 3'd2); s.rvalid = 1; s.rdata = 32'hDEADBEEF;
        e = base_exp(32'h1000); e.busy = 1; e.dvalid = 1; e.sbdata = 32'hDEADBEEF; push(s, e);
        s = base_stim(32'h1000, 3'd2);
        e = base_exp(32'h1000); push(s, e);
        // Byte write at the top lane.
        s = base_stim(32'h1003, 3'd0); s.data_wv = 1; s.data = 32'hAB;
        e = base_exp(32'h1003); push(s, e);
        s = base_stim(32'h1003, 3'd0); s.gnt = 1; s.data = 32'hAB;
        e = base_exp(32'h1003); e.req = 1; e.we = 1; e.be = 4'b1000;
        e.wdata = 32'hAB000000; e.busy = 1; push(s, e);
        s = base_stim(32'h1003, 3'd0); s.rvalid = 1;
        e = base_exp(32'h1003); e.busy = 1; push(s, e);
        s = base_stim(32'h1003, 3'd0);
        e = base_exp(32'h1003); push(s, e);
        // Auto-increment on read completion.
        s = base_stim(32'h2000, 3'd2); s.addr_wv = 1; s.roa = 1; s.autoinc = 1;
        e = base_exp(32'h2000); push(s, e);
        s = base_stim(32'h2000, 3'd2); s.gnt = 1; s.autoinc = 1;
        e = base_exp(32'h2000); e.req = 1; e.be = 4'hF; e.busy = 1; push(s, e);
        s = base_stim(32'h2000, 3'd2); s.rvalid = 1; s.autoinc = 1; s.rdata = 32'h0BADF00D;
        e = base_exp(32'h2000); e.busy = 1; e.dvalid = 1; e.sbdata = 32'h0BADF00D;
        e.addr_o = AutoIncEn ? 32'h2004 : 32'h2000; push(s, e);
        s = base_stim(32'h2004, 3'd2); s.autoinc = 1;
        e = base_exp(32'h2004); push(s, e);
        // 64-bit access on a 32-bit bus: error pulse, no request.
        s = base_stim(32'h3000, 3'd3); s.data_wv = 1;
        e = base_exp(32'h3000); push(s, e);
        s = base_stim(32'h3000, 3'd3); s.gnt = 1;
        e = base_exp(32'h3000); e.busy = 1; e.errv = 1; e.err = 3'd4; push(s, e);
        s = base_stim(32'h3000, 3'd3);
        e = base_exp(32'h3000); push(s, e);
    endtask

    task automatic delayed_grant_seq();
        stim_t s;
        expect_t e;
        s = base_stim(32'h400A, 3'd1); s.addr_wv = 1; s.roa = 1;
        e = base_exp(32'h400A); run_cycle("dly trig", s, e);
        for (int i = 0; i < 3; i++) begin
            s = base_stim(32'h400A, 3'd1);
            e = base_exp(32'h400A); e.req = 1; e.be = 4'b1100; e.busy = 1;
            run_cycle("dly wait", s, e);
        end
        s = base_stim(32'h400A, 3'd1); s.gnt = 1;
        e = base_exp(32'h400A); e.req = 1; e.be = 4'b1100; e.busy = 1;
        run_cycle("dly gnt", s, e);
        s = base_stim(32'h400A, 3'd1); s.rvalid = 1; s.rdata = 32'h12345678;
        e = base_exp(32'h400A); e.busy = 1; e.dvalid = 1; e.sbdata = 32'h00001234;
        run_cycle("dly resp", s, e);
    endtask

    task automatic dmactive_drop_seq();
        stim_t s;
        expect_t e;
        s = base_stim(32'h5000, 3'd2); s.data_rv = 1; s.rod = 1;
        e = base_exp(32'h5000); run_cycle("drop trig", s, e);
        s = base_stim(32'h5000, 3'd2); s.gnt = 1;
        e = base_exp(32'h5000); e.req = 1; e.be = 4'hF; e.busy = 1;
        run_cycle("drop gnt", s, e);
        s = base_stim(32'h5000, 3'd2); s.dmactive = 0;
        e = base_exp(32'h5000); e.busy = 1;
        run_cycle("drop low", s, e);
        s = base_stim(32'h5000, 3'd2); s.rvalid = 1; s.rdata = 32'hCAFE0001;
        e = base_exp(32'h5000);
        run_cycle("drop late", s, e);
    endtask

    task automatic random_run(input int cycles);
        bit m_busy = 0, m_read = 0, m_granted = 0;
        bit size_err, complete;
        stim_t s;
        expect_t e;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            s          = '0;
            s.dmactive = ($urandom_range(0, 15) != 0);
            s.addr     = $urandom;
            s.addr_wv  = ($urandom_range(0, 3) == 0);
            s.roa      = 1'($urandom);
            s.autoinc  = 1'($urandom);
            s.rod      = 1'($urandom);
            s.access   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                     : 3'($urandom_range(0, 2));
            s.data     = $urandom;
            s.data_rv  = ($urandom_range(0, 3) == 0);
            s.data_wv  = ($urandom_range(0, 5) == 0);
            s.gnt      = 1'($urandom);
            s.rvalid   = 1'($urandom);
            s.rdata    = $urandom;

            size_err = m_busy && (s.access > 3'd2);
            complete = s.dmactive && m_busy && m_granted && !size_err && s.rvalid;
            e        = base_exp(s.addr);
            e.busy   = m_busy;
            e.req    = m_busy && !m_granted && !size_err;
            e.we     = e.req && !m_read;
            e.be     = e.req ? lane_mask(s.addr[1:0], int'(s.access)) : 4'h0;
            e.wdata  = s.data << (8 * int'(s.addr[1:0]));
            e.dvalid = complete && m_read;
            e.sbdata = s.rdata >> (8 * aligned_off(s.addr[1:0], int'(s.access)));
            e.errv   = s.dmactive && size_err;
            e.err    = e.errv ? 3'd4 : 3'd0;
            if (AutoIncEn && complete && s.autoinc)
                e.addr_o = s.addr + (32'd1 << s.access);
            run_cycle("rand", s, e);

            if (!s.dmactive) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (s.addr_wv && s.roa) begin
                    m_busy = 1; m_read = 1; m_granted = 0;
                end else if (s.data_wv) begin
                    m_busy = 1; m_read = 0; m_granted = 0;
                end else if (s.data_rv && s.rod) begin
                    m_busy = 1; m_read = 1; m_granted = 0;
                end
            end else if (size_err) begin
                m_busy = 0;
            end else if (!m_granted) begin
                if (s.gnt) m_granted = 1;
            end else if (s.rvalid) begin
                m_busy = 0;
            end
        end
    endtask

    initial begin
        stim_t s;
        expect_t e;
        rst_n = 1'b0;
        s = base_stim(32'h55AA, 3'd0);
        s.dmactive = 0;
        apply_stimulus(s);
        #2;
        e = base_exp(32'h55AA);
        check_output("reset", e);
        check("reset wdata", wdata, 32'h0);
        check("reset sbdata", sbdata_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
        end

        delayed_grant_seq();
        dmactive_drop_seq();
        random_run(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/dm_sysbus_access.md
# dm_sysbus_access

System Bus Access (SBA) engine of the RISC-V debug module (spec 0.13). It turns sbaddress/sbdata register events from the DM CSR block into single-beat reads and writes on a req/gnt/r_valid bus master port. It returns read data, advances the address on auto-increment, and reports busy and error status back to the CSR block.

## Interface
- BusWidth, default 32: address and data width; legal values are 32 and 64.
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dmactive_i  in  1  debug module active; low aborts to Idle
- master_req_o  out  1  bus request
- master_add_o  out  BusWidth  bus address
- master_we_o  out  1  write enable
- master_wdata_o  out  BusWidth  write data
- master_be_o  out  BusWidth/8  byte enables
- master_gnt_i  in  1  request granted
- master_r_valid_i  in  1  response valid (reads and writes)
- master_r_rdata_i  in  BusWidth  read data
- sbaddress_i  in  BusWidth  current sbaddress CSR
- sbaddress_o  out  BusWidth  next sbaddress value
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress
- sbreadonaddr_i, sbautoincrement_i, sbreadondata_i  in  1 each  sbcs control bits
- sbaccess_i  in  3  access size, log2 of bytes
- sbdata_i  in  BusWidth  sbdata CSR value to write
- sbdata_read_valid_i  in  1  debugger read sbdata0
- sbdata_write_valid_i  in  1  debugger wrote sbdata0
- sbdata_o  out  BusWidth  read result, right-aligned
- sbdata_valid_o  out  1  one-cycle pulse, read data valid
- sbbusy_o  out  1  engine busy
- sberror_valid_o  out  1  one-cycle error pulse
- sberror_o  out  3  error code

## Operation
- States: Idle, Read, Write, WaitRead, WaitWrite. sbbusy_o = (state != Idle).
- Idle transitions, checked in priority order:
  - sbaddress_write_valid_i && sbreadonaddr_i → Read.
  - Otherwise sbdata_write_valid_i → Write.
  - Otherwise sbdata_read_valid_i && sbreadondata_i → Read.
- Read: master_req_o=1, master_we_o=0. On master_gnt_i → WaitRead.
- Write: master_req_o=1, master_we_o=1. On master_gnt_i → WaitWrite.
- WaitRead: on master_r_valid_i, pulse sbdata_valid_o, increment the address, → Idle.
- WaitWrite: on master_r_valid_i, increment the address, → Idle.
- master_add_o = sbaddress_i in all states.
- Byte offset off = sbaddress_i[log2(BusWidth/8)-1:0].
- master_be_o:
  - size 0: one byte at off.
  - size 1: two bytes at off aligned down to 2.
  - size 2: four bytes at off aligned down to 4.
  - size 3: all eight bytes.
  - master_be_o = 0 when master_req_o = 0.
- Data alignment:
  - master_wdata_o = sbdata_i << 8·off.
  - sbdata_o = master_r_rdata_i >> 8·off (aligned-down off for the access size).
- Address increment: sbaddress_o = sbaddress_i + (1 << sbaccess_i) in the completion cycle when sbautoincrement_i=1. In all other cycles sbaddress_o = sbaddress_i. Width wraps modulo 2^BusWidth.
- Size error: in any non-Idle state where sbaccess_i > log2(BusWidth/8):
  - master_req_o = 0 and the state returns to Idle.
  - sberror_valid_o = 1, sberror_o = 3'd4 (size unsupported).
  - No bus access is issued.
- sberror_o = 0 when not valid. No other error codes are generated.
- dmactive_i low forces the next state to Idle from any state and suppresses all pulses. An outstanding response arriving later is ignored.

## Timing
- Registered state only. All other outputs are combinational from state and inputs.
- Reset: state Idle, so all outputs are 0 except master_add_o (= sbaddress_i) and sbaddress_o (= sbaddress_i).
- Minimum latency from trigger to sbdata_valid_o is 2 cycles: trigger cycle → Read with grant in the same cycle → WaitRead with r_valid → pulse.
- Trigger events are ignored while busy; the CSR block flags sbbusyerror.
- master_req_o is held until master_gnt_i. A response in the grant cycle is not accepted; it is taken in WaitRead/WaitWrite only.

## Configuration
- DM_SBA_AUTOINCREMENT_EN defined: auto-increment behaves as above.
- DM_SBA_AUTOINCREMENT_EN undefined: sbautoincrement_i is ignored and sbaddress_o = sbaddress_i always.

## Structure
- Shared package dm holds:
  - sberror code constants (0 none, 4 size).
  - sbaccess size encodings.
- The state enum is local to the block.
- Sub-module dm_sba_be_gen is natural: sbaccess + address offset → byte-enable mask and shift amount.

## Test plan
- BusWidth=32, sbaddress write 0x1000 with readonaddr=1, sbaccess=2, gnt immediate, r_valid next cycle with rdata 0xDEADBEEF → sbdata_o=0xDEADBEEF, sbdata_valid_o one pulse, sbbusy 1 for 2 cycles.
- sbdata write 0x000000AB, sbaccess=0, addr 0x1003 → be=4'b1000, wdata=0xAB000000, we=1.
- Autoincrement, sbaccess=2, addr 0x2000, read completes → sbaddress_o=0x2004 during the completion cycle.
- sbaccess=3 with BusWidth=32 on a write trigger → no master_req, sberror_valid pulse, sberror_o=4, back to Idle.
- Gnt delayed 3 cycles → req held high and stable, address held stable, busy throughout.
- dmactive_i dropped while in WaitRead → Idle next cycle; a later r_valid produces no sbdata_valid_o.
